// File: rtl/spike_event_scheduler_pkg.sv
// Shared types for the spike event scheduler.
// Holds the FSM state enum and AER beat field widths.
package snn_pkg;

  localparam int AER_ID_W = 8;
  localparam int AER_TS_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    EOT   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/spike_event_scheduler_if.sv
// AER output stream: valid/ready beat carrying id, eot, ts.
// master = scheduler, slave = event consumer.
interface spike_event_scheduler_if #(
  parameter int ID_WIDTH = 8,
  parameter int TS_WIDTH = 16
) ();
  logic                aer_valid;
  logic                aer_ready;
  logic [ID_WIDTH-1:0] aer_id;
  logic                aer_eot;
  logic [TS_WIDTH-1:0] aer_ts;

  modport master (
    output aer_valid,
    output aer_id,
    output aer_eot,
    output aer_ts,
    input  aer_ready
  );

  modport slave (
    input  aer_valid,
    input  aer_id,
    input  aer_eot,
    input  aer_ts,
    output aer_ready
  );
endinterface

// File: rtl/spike_prio_enc.sv
// Lowest-set-bit priority encoder (combinational).
// vec_i: request mask; idx_o: lowest set index; any_o: mask nonzero.
module spike_prio_enc #(
  parameter int NUM_NEURONS = 256,
  parameter int ID_WIDTH    = 8
) (
  input  logic [NUM_NEURONS-1:0] vec_i,
  output logic [ID_WIDTH-1:0]    idx_o,
  output logic                   any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Scan downward so the lowest set bit wins.
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/spike_event_scheduler.sv
// Timestep scheduler: steps the neuron array, drains spikes as AER beats.
// Ports: clk/rst, start/num_steps/stop, busy/done, core_step/core_spike, aer, stat_spikes.
module spike_event_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 256,
  parameter int ID_WIDTH    = AER_ID_W,
  parameter int TS_WIDTH    = AER_TS_W,
  parameter int CORE_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [TS_WIDTH-1:0]    num_steps,
  input  logic                   stop,
  output logic                   busy,
  output logic                   done,
  output logic                   core_step,
  input  logic [NUM_NEURONS-1:0] core_spike,
  spike_event_scheduler_if.master aer,
  output logic [31:0]            stat_spikes
);

  localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  sched_state_e           state_q, state_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [TS_WIDTH-1:0]    nsteps_q, nsteps_d;
  logic [NUM_NEURONS-1:0] pend_q, pend_d;
  logic                   stop_q, stop_d;
  logic [31:0]            stat_q, stat_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   done_q, done_d;

  logic [ID_WIDTH-1:0]    enc_idx;
  logic                   enc_any;
  logic [TS_WIDTH:0]      ts_nxt;
  logic                   last_step;

  spike_prio_enc #(
    .NUM_NEURONS (NUM_NEURONS),
    .ID_WIDTH    (ID_WIDTH)
  ) u_enc (
    .vec_i (pend_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Extra bit so ts+1 cannot wrap before the compare.
  assign ts_nxt    = {1'b0, ts_q} + 1'b1;
  assign last_step = (ts_nxt == {1'b0, nsteps_q});

  always_comb begin
    state_d  = state_q;
    ts_d     = ts_q;
    nsteps_d = nsteps_q;
    pend_d   = pend_q;
    stop_d   = stop_q;
    stat_d   = stat_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    if (state_q != IDLE && stop) stop_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          if (num_steps != '0) begin
            nsteps_d = num_steps;
            ts_d     = '0;
            stat_d   = '0;
            state_d  = STEP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STEP: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(CORE_LAT - 1)) begin
          pend_d  = core_spike;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!enc_any) begin
          state_d = EOT;
        end else if (aer.aer_ready) begin
          // x & (x-1) clears exactly the lowest set bit.
          pend_d = pend_q & (pend_q - 1'b1);
          if (stat_q != '1) stat_d = stat_q + 32'd1;
        end
      end
      EOT: begin
        if (aer.aer_ready) begin
          if (last_step || stop_q || stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end else begin
            ts_d    = ts_nxt[TS_WIDTH-1:0];
            state_d = STEP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      nsteps_q <= '0;
      pend_q   <= '0;
      stop_q   <= 1'b0;
      stat_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      nsteps_q <= nsteps_d;
      pend_q   <= pend_d;
      stop_q   <= stop_d;
      stat_q   <= stat_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign core_step     = (state_q == STEP);
  assign stat_spikes   = stat_q;
  assign aer.aer_valid = ((state_q == DRAIN) && enc_any) || (state_q == EOT);
  assign aer.aer_eot   = (state_q == EOT);
  assign aer.aer_id    = (state_q == DRAIN) ? enc_idx : '0;
  assign aer.aer_ts    = ts_q;

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Scoreboard bench for spike_event_scheduler.
// Expected AER beats are queued at stimulus time and popped on handshake.
module tb_spike_event_scheduler;
  import snn_pkg::*;

  localparam int N   = 256;
  localparam int IDW = 8;
  localparam int TSW = 16;

  logic           clk;
  logic           rst;
  logic           start;
  logic [TSW-1:0] num_steps;
  logic           stop;
  logic           busy;
  logic           done;
  logic           core_step;
  logic [N-1:0]   core_spike;
  logic [31:0]    stat_spikes;

  spike_event_scheduler_if #(.ID_WIDTH(IDW), .TS_WIDTH(TSW)) aer ();

  spike_event_scheduler #(
    .NUM_NEURONS (N),
    .ID_WIDTH    (IDW),
    .TS_WIDTH    (TSW),
    .CORE_LAT    (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_steps   (num_steps),
    .stop        (stop),
    .busy        (busy),
    .done        (done),
    .core_step   (core_step),
    .core_spike  (core_spike),
    .aer         (aer.master),
    .stat_spikes (stat_spikes)
  );

  int n_chk;
  int n_fail;
  int step_cnt;
  int done_cnt;
  int rmode;
  logic [IDW+TSW:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ready pattern: 0 = always ready, 1 = toggle, other = held low.
  initial begin
    aer.aer_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       aer.aer_ready = 1'b1;
        1:       aer.aer_ready = ~aer.aer_ready;
        default: aer.aer_ready = 1'b0;
      endcase
    end
  end

  logic             pv, pr;
  logic [IDW+TSW:0] pbeat;

  always @(negedge clk) begin
    logic [IDW+TSW:0] cur;
    logic [IDW+TSW:0] e;
    cur = {aer.aer_eot, aer.aer_id, aer.aer_ts};
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (core_step) step_cnt++;
      if (done) done_cnt++;
      if (pv && !pr) begin
        chk("stall_valid", 64'(aer.aer_valid), 64'd1);
        chk("stall_beat", 64'(cur), 64'(pbeat));
      end
      if (aer.aer_valid && aer.aer_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 64'(cur), 64'(e));
        end
      end
      pv    = aer.aer_valid;
      pr    = aer.aer_ready;
      pbeat = cur;
    end
  end

  task automatic push_exp(input int n, input logic [N-1:0] sp);
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < N; i++)
        if (sp[i]) exp_q.push_back({1'b0, IDW'(i), TSW'(t)});
      exp_q.push_back({1'b1, {IDW{1'b0}}, TSW'(t)});
    end
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk);
    #1;
    num_steps = TSW'(n);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input int n, input logic [N-1:0] sp, input int mode);
    int s0;
    s0         = step_cnt;
    core_spike = sp;
    rmode      = mode;
    push_exp(n, sp);
    pulse_start(n);
    wait_done(5000);
    @(negedge clk);
    chk("steps", 64'(step_cnt - s0), 64'(n));
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("stat", 64'(stat_spikes), 64'(n * $countones(sp)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] sp;
    int s0, d0, c;
    n_chk      = 0;
    n_fail     = 0;
    step_cnt   = 0;
    done_cnt   = 0;
    rmode      = 0;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    num_steps  = '0;
    core_spike = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_step", 64'(core_step), 64'd0);
    chk("rst_valid", 64'(aer.aer_valid), 64'd0);
    chk("rst_eot", 64'(aer.aer_eot), 64'd0);
    chk("rst_stat", 64'(stat_spikes), 64'd0);
    chk("rst_id", 64'(aer.aer_id), 64'd0);
    chk("rst_ts", 64'(aer.aer_ts), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two spikes, one timestep.
    run(1, N'(5), 0);

    // Empty captures over three timesteps.
    run(3, '0, 0);

    // Full vector with stalling consumer.
    run(1, '1, 1);

    // Stop during the drain of ts=3; mid-run start and num_steps ignored.
    sp = '0;
    sp[1] = 1'b1;
    sp[7] = 1'b1;
    sp[200] = 1'b1;
    core_spike = sp;
    rmode = 0;
    s0 = step_cnt;
    push_exp(4, sp);
    pulse_start(10);
    repeat (3) @(posedge clk);
    #1;
    num_steps = TSW'(2);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 0;
    @(negedge clk);
    while (!(aer.aer_valid && !aer.aer_eot && aer.aer_ts == 3) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("stop_window", 64'(aer.aer_ts), 64'd3);
    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    wait_done(2000);
    repeat (10) @(negedge clk);
    chk("stop_steps", 64'(step_cnt - s0), 64'd4);
    chk("stop_sb", 64'(exp_q.size()), 64'd0);
    chk("stop_stat", 64'(stat_spikes), 64'd12);

    // Reset in the middle of a stalled drain with five pending.
    core_spike = N'(32'h0000_1F00);
    rmode = 2;
    pulse_start(4);
    c = 0;
    @(negedge clk);
    while (!aer.aer_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("pre_rst_id", 64'(aer.aer_id), 64'd8);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(aer.aer_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_id", 64'(aer.aer_id), 64'd0);
    chk("mid_rst_ts", 64'(aer.aer_ts), 64'd0);
    chk("mid_rst_stat", 64'(stat_spikes), 64'd0);
    repeat (5) @(negedge clk);
    chk("mid_rst_nodone", 64'(done_cnt - d0), 64'd0);
    exp_q.delete();
    run(2, N'(32'h8000_0001), 0);

    // Zero-length run.
    s0 = step_cnt;
    pulse_start(0);
    wait_done(2);
    repeat (5) @(negedge clk);
    chk("zero_steps", 64'(step_cnt - s0), 64'd0);
    chk("zero_sb", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
